rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob_pkg.sv | 25 ++
 rtl/rob.sv | 142 ++++++++++++++
 tb/tb_rob.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared core types for the reorder buffer: register/index types, entry layout and FSM states.
package rob_pkg;

    localparam int ARCH_REG_W = 5;
    localparam int PHY_REG_W  = 6;
    localparam int ROB_IDX_W  = 5;

    typedef logic [ARCH_REG_W-1:0] arch_reg_t;
    typedef logic [PHY_REG_W-1:0]  phy_reg_t;
    typedef logic [ROB_IDX_W-1:0]  rob_idx_t;

    typedef struct packed {
        arch_reg_t arch_dst;
        phy_reg_t  phy_dst;
        phy_reg_t  phy_dst_old;
        logic      has_dst;
        logic      done;
    } rob_entry_t;

    typedef enum logic {
        ROB_NORMAL = 1'b0,
        ROB_REWIND = 1'b1
    } rob_state_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order dispatch/retire of WIDTH lanes, out-of-order completion,
// and a multi-cycle walk-back (rewind) of entries younger than a mispredicted branch.
//
// state      | meaning
// ROB_NORMAL | dispatch, complete and retire; a mispredict may start a rewind
// ROB_REWIND | remove up to RW_WIDTH entries per cycle from tail-1 down to target+1
module rob
    import rob_pkg::*;
#(
    parameter int SIZE     = 32,   // power of two, 4..2**ROB_IDX_W
    parameter int WIDTH    = 2,
    parameter int RW_WIDTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [WIDTH-1:0]    dispatch_valid,
    input  logic [WIDTH-1:0]    dispatch_has_dst,
    input  arch_reg_t           dispatch_arch_dst    [WIDTH],
    input  phy_reg_t            dispatch_phy_dst     [WIDTH],
    input  phy_reg_t            dispatch_phy_dst_old [WIDTH],
    output logic                dispatch_ready,
    output rob_idx_t            dispatch_idx         [WIDTH],
    input  logic [WIDTH-1:0]    complete_valid,
    input  rob_idx_t            complete_idx         [WIDTH],
    input  logic                mispredict_valid,
    input  rob_idx_t            mispredict_idx,
    output logic [WIDTH-1:0]    retire_valid,
    output arch_reg_t           retire_arch_dst      [WIDTH],
    output phy_reg_t            retire_phy_dst       [WIDTH],
    output phy_reg_t            retire_phy_dst_old   [WIDTH],
    output logic [RW_WIDTH-1:0] rewind_valid,
    output arch_reg_t           rewind_arch_dst      [RW_WIDTH],
    output phy_reg_t            rewind_phy_dst       [RW_WIDTH],
    output phy_reg_t            rewind_phy_dst_old   [RW_WIDTH],
    output logic                rewinding
);

    localparam int CW = $clog2(SIZE + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam rob_idx_t IDX_MASK = rob_idx_t'(SIZE - 1);
    localparam cnt_t     SIZE_CNT = cnt_t'(SIZE);

    rob_entry_t entries [SIZE];
    rob_idx_t   head, tail, target, target_nx;
    cnt_t       count, count_nx;
    rob_state_t state, state_nx;

    cnt_t       disp_cnt, disp_acc, ret_cnt, rw_cnt, rw_left, keep_cnt;
    logic       run;
    logic [WIDTH-1:0] comp_ok;
    rob_idx_t   ret_idx [WIDTH];
    rob_idx_t   rw_idx  [RW_WIDTH];

    assign rewinding = (state == ROB_REWIND);

    always_comb begin
        dispatch_ready = (state == ROB_NORMAL) && !mispredict_valid
                         && ((SIZE_CNT - count) >= cnt_t'(WIDTH));
        disp_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dispatch_idx[i] = (tail + rob_idx_t'(disp_cnt)) & IDX_MASK;
            if (dispatch_valid[i]) disp_cnt = disp_cnt + cnt_t'(1);
        end
        disp_acc = dispatch_ready ? disp_cnt : '0;

        // Entries strictly younger than the branch still left to remove.
        rw_left = cnt_t'((tail - target - rob_idx_t'(1)) & IDX_MASK);
        rw_cnt  = '0;
        if (state == ROB_REWIND)
            rw_cnt = (rw_left < cnt_t'(RW_WIDTH)) ? rw_left : cnt_t'(RW_WIDTH);
        for (int j = 0; j < RW_WIDTH; j++) begin
            rw_idx[j]             = (tail - rob_idx_t'(j + 1)) & IDX_MASK;
            rewind_valid[j]       = (cnt_t'(j) < rw_cnt) && entries[rw_idx[j]].has_dst;
            rewind_arch_dst[j]    = entries[rw_idx[j]].arch_dst;
            rewind_phy_dst[j]     = entries[rw_idx[j]].phy_dst;
            rewind_phy_dst_old[j] = entries[rw_idx[j]].phy_dst_old;
        end

        // Retire never reaches into entries that are scheduled for removal.
        keep_cnt = (state == ROB_REWIND) ? (count - rw_left) : count;
        ret_cnt  = '0;
        run      = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            ret_idx[i]            = (head + rob_idx_t'(i)) & IDX_MASK;
            run                   = run && (cnt_t'(i) < keep_cnt) && entries[ret_idx[i]].done;
            retire_valid[i]       = run;
            retire_arch_dst[i]    = entries[ret_idx[i]].arch_dst;
            retire_phy_dst[i]     = entries[ret_idx[i]].phy_dst;
            retire_phy_dst_old[i] = entries[ret_idx[i]].phy_dst_old;
            if (run) ret_cnt = ret_cnt + cnt_t'(1);
        end

        for (int i = 0; i < WIDTH; i++)
            comp_ok[i] = complete_valid[i] && !((state == ROB_REWIND) &&
                (cnt_t'((tail - rob_idx_t'(1) - complete_idx[i]) & IDX_MASK) < rw_cnt));

        count_nx  = count + disp_acc - ret_cnt - rw_cnt;
        state_nx  = state;
        target_nx = target;
        case (state)
            ROB_NORMAL: begin
                if (mispredict_valid &&
                    (mispredict_idx != ((tail - rob_idx_t'(1)) & IDX_MASK))) begin
                    state_nx  = ROB_REWIND;
                    target_nx = mispredict_idx & IDX_MASK;
                end
            end
            ROB_REWIND: begin
                if ((rw_cnt == rw_left) || (count_nx == '0)) state_nx = ROB_NORMAL;
            end
            default: state_nx = ROB_NORMAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            target <= '0;
            state  <= ROB_NORMAL;
            for (int k = 0; k < SIZE; k++) entries[k].done <= 1'b0;
        end else begin
            head   <= (head + rob_idx_t'(ret_cnt)) & IDX_MASK;
            tail   <= (tail + rob_idx_t'(disp_acc) - rob_idx_t'(rw_cnt)) & IDX_MASK;
            count  <= count_nx;
            target <= target_nx;
            state  <= state_nx;
            for (int i = 0; i < WIDTH; i++)
                if (comp_ok[i]) entries[complete_idx[i]].done <= 1'b1;
            // A freshly dispatched entry overrides any stale completion to the same slot.
            for (int i = 0; i < WIDTH; i++)
                if (dispatch_ready && dispatch_valid[i])
                    entries[dispatch_idx[i]] <= '{arch_dst:    dispatch_arch_dst[i],
                                                  phy_dst:     dispatch_phy_dst[i],
                                                  phy_dst_old: dispatch_phy_dst_old[i],
                                                  has_dst:     dispatch_has_dst[i],
                                                  done:        1'b0};
        end
    end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: queue-based reference model checked every cycle, plus literal pins.
module tb_rob;
    import rob_pkg::*;

    localparam int SIZE = 32;
    localparam int WIDTH = 2;
    localparam int RW = 2;

    logic clock = 1'b0;
    logic reset;
    logic [WIDTH-1:0] dispatch_valid, dispatch_has_dst;
    arch_reg_t dispatch_arch_dst [WIDTH];
    phy_reg_t  dispatch_phy_dst [WIDTH];
    phy_reg_t  dispatch_phy_dst_old [WIDTH];
    logic      dispatch_ready;
    rob_idx_t  dispatch_idx [WIDTH];
    logic [WIDTH-1:0] complete_valid;
    rob_idx_t  complete_idx [WIDTH];
    logic      mispredict_valid;
    rob_idx_t  mispredict_idx;
    logic [WIDTH-1:0] retire_valid;
    arch_reg_t retire_arch_dst [WIDTH];
    phy_reg_t  retire_phy_dst [WIDTH];
    phy_reg_t  retire_phy_dst_old [WIDTH];
    logic [RW-1:0] rewind_valid;
    arch_reg_t rewind_arch_dst [RW];
    phy_reg_t  rewind_phy_dst [RW];
    phy_reg_t  rewind_phy_dst_old [RW];
    logic      rewinding;

    always #5 clock = ~clock;

    rob #(.SIZE(SIZE), .WIDTH(WIDTH), .RW_WIDTH(RW)) dut (
        .clock(clock), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_has_dst(dispatch_has_dst),
        .dispatch_arch_dst(dispatch_arch_dst), .dispatch_phy_dst(dispatch_phy_dst),
        .dispatch_phy_dst_old(dispatch_phy_dst_old),
        .dispatch_ready(dispatch_ready), .dispatch_idx(dispatch_idx),
        .complete_valid(complete_valid), .complete_idx(complete_idx),
        .mispredict_valid(mispredict_valid), .mispredict_idx(mispredict_idx),
        .retire_valid(retire_valid), .retire_arch_dst(retire_arch_dst),
        .retire_phy_dst(retire_phy_dst), .retire_phy_dst_old(retire_phy_dst_old),
        .rewind_valid(rewind_valid), .rewind_arch_dst(rewind_arch_dst),
        .rewind_phy_dst(rewind_phy_dst), .rewind_phy_dst_old(rewind_phy_dst_old),
        .rewinding(rewinding)
    );

    int errors = 0;
    int checks = 0;
    int tag = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: in-flight entries oldest-first; doomed = younger than a pending mispredict.
    typedef struct {
        int idx;
        int arch;
        int phy;
        int old;
        bit has;
        bit done;
        bit doomed;
    } m_ent_t;

    m_ent_t q[$];
    int m_tail = 0;
    bit m_rewind = 0;

    always @(negedge clock) begin
        int n_ret, n_rw, n_doom, acc, pos, tail_prev;
        bit exp_ready, was_rw, exp_rv;
        m_ent_t e;
        if (reset) begin
            q.delete();
            m_tail   = 0;
            m_rewind = 0;
        end else begin
            n_doom = 0;
            foreach (q[k]) if (q[k].doomed) n_doom++;
            n_rw = m_rewind ? ((n_doom < RW) ? n_doom : RW) : 0;
            n_ret = 0;
            while (n_ret < WIDTH && n_ret < q.size() && q[n_ret].done && !q[n_ret].doomed) n_ret++;
            exp_ready = !m_rewind && !mispredict_valid && (SIZE - q.size() >= WIDTH);

            check("m_ready", int'(dispatch_ready), int'(exp_ready));
            check("m_rewinding", int'(rewinding), int'(m_rewind));
            for (int i = 0; i < WIDTH; i++) begin
                check($sformatf("m_retire_valid[%0d]", i), int'(retire_valid[i]), int'(i < n_ret));
                if (i < n_ret) begin
                    check($sformatf("m_retire_arch[%0d]", i), int'(retire_arch_dst[i]), q[i].arch);
                    check($sformatf("m_retire_phy[%0d]", i), int'(retire_phy_dst[i]), q[i].phy);
                    check($sformatf("m_retire_old[%0d]", i), int'(retire_phy_dst_old[i]), q[i].old);
                end
            end
            for (int j = 0; j < RW; j++) begin
                exp_rv = (j < n_rw) && q[q.size() - 1 - j].has;
                check($sformatf("m_rewind_valid[%0d]", j), int'(rewind_valid[j]), int'(exp_rv));
                if (exp_rv) begin
                    check($sformatf("m_rewind_arch[%0d]", j), int'(rewind_arch_dst[j]), q[q.size() - 1 - j].arch);
                    check($sformatf("m_rewind_phy[%0d]", j), int'(rewind_phy_dst[j]), q[q.size() - 1 - j].phy);
                    check($sformatf("m_rewind_old[%0d]", j), int'(rewind_phy_dst_old[j]), q[q.size() - 1 - j].old);
                end
            end
            acc = 0;
            if (exp_ready)
                for (int i = 0; i < WIDTH; i++)
                    if (dispatch_valid[i]) begin
                        check($sformatf("m_dispatch_idx[%0d]", i), int'(dispatch_idx[i]), (m_tail + acc) % SIZE);
                        acc++;
                    end

            was_rw    = m_rewind;
            tail_prev = m_tail;
            repeat (n_ret) void'(q.pop_front());
            repeat (n_rw) void'(q.pop_back());
            m_tail = (m_tail - n_rw + SIZE) % SIZE;
            if (m_rewind && n_doom == n_rw) m_rewind = 0;
            for (int i = 0; i < WIDTH; i++)
                if (complete_valid[i])
                    foreach (q[k]) if (q[k].idx == int'(complete_idx[i])) q[k].done = 1;
            if (!was_rw && mispredict_valid && int'(mispredict_idx) != (tail_prev + SIZE - 1) % SIZE) begin
                pos = -1;
                foreach (q[k]) if (q[k].idx == int'(mispredict_idx)) pos = k;
                for (int k = pos + 1; k < q.size(); k++) q[k].doomed = 1;
                m_rewind = 1;
            end
            if (exp_ready)
                for (int i = 0; i < WIDTH; i++)
                    if (dispatch_valid[i]) begin
                        e.idx = m_tail; e.arch = int'(dispatch_arch_dst[i]);
                        e.phy = int'(dispatch_phy_dst[i]); e.old = int'(dispatch_phy_dst_old[i]);
                        e.has = dispatch_has_dst[i]; e.done = 0; e.doomed = 0;
                        q.push_back(e);
                        m_tail = (m_tail + 1) % SIZE;
                    end
        end
    end

    task automatic idle();
        dispatch_valid = '0;
        dispatch_has_dst = '0;
        complete_valid = '0;
        mispredict_valid = 1'b0;
        mispredict_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dispatch_arch_dst[i] = '0; dispatch_phy_dst[i] = '0;
            dispatch_phy_dst_old[i] = '0; complete_idx[i] = '0;
        end
    endtask

    // Payload of the n-th dispatched lane since reset: arch=n, phy=n+7, old=n+40.
    task automatic drive_disp(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] has);
        dispatch_valid = v;
        dispatch_has_dst = has;
        for (int i = 0; i < WIDTH; i++) begin
            dispatch_arch_dst[i] = arch_reg_t'(tag);
            dispatch_phy_dst[i] = phy_reg_t'(tag + 7);
            dispatch_phy_dst_old[i] = phy_reg_t'(tag + 40);
            if (v[i]) tag++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tag = 0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_ready", int'(dispatch_ready), 1);
        check("reset_retire_valid", int'(retire_valid), 0);
        check("reset_rewind_valid", int'(rewind_valid), 0);
        check("reset_rewinding", int'(rewinding), 0);
        next_cycle();

        // Fill all 32 entries
        for (int c = 0; c < 16; c++) begin
            drive_disp(2'b11, 2'b01);
            @(negedge clock);
            check("fill_idx0", int'(dispatch_idx[0]), 2 * c);
            check("fill_idx1", int'(dispatch_idx[1]), 2 * c + 1);
            next_cycle();
        end
        @(negedge clock);
        check("full_ready", int'(dispatch_ready), 0);

        // Out-of-order completion holds retire until the head completes
        next_cycle();
        complete_valid = 2'b01; complete_idx[0] = 5'd1;
        next_cycle();
        @(negedge clock);
        check("ooo_no_retire", int'(retire_valid), 0);
        next_cycle();
        complete_valid = 2'b01; complete_idx[0] = 5'd0;
        next_cycle();
        @(negedge clock);
        check("ooo_retire_both", int'(retire_valid), 3);
        check("ooo_retire_phy0", int'(retire_phy_dst[0]), 7);
        check("ooo_retire_arch1", int'(retire_arch_dst[1]), 1);
        next_cycle();

        // Rewind of 10 entries back to branch 3; idx 5 and 8 have no destination
        do_reset();
        drive_disp(2'b11, 2'b11); next_cycle();
        drive_disp(2'b11, 2'b11); next_cycle();
        drive_disp(2'b11, 2'b01); next_cycle();
        drive_disp(2'b11, 2'b11); next_cycle();
        drive_disp(2'b11, 2'b10); next_cycle();
        mispredict_valid = 1'b1; mispredict_idx = 5'd3;
        complete_valid = 2'b11; complete_idx[0] = 5'd0; complete_idx[1] = 5'd1;
        @(negedge clock);
        check("mp_ready", int'(dispatch_ready), 0);
        next_cycle();
        complete_valid = 2'b11; complete_idx[0] = 5'd2; complete_idx[1] = 5'd9;
        @(negedge clock);
        check("rw1_rewinding", int'(rewinding), 1);
        check("rw1_valid", int'(rewind_valid), 1);
        check("rw1_phy0", int'(rewind_phy_dst[0]), 16);
        check("rw1_ready", int'(dispatch_ready), 0);
        next_cycle();
        complete_valid = 2'b01; complete_idx[0] = 5'd3;
        @(negedge clock);
        check("rw2_valid", int'(rewind_valid), 3);
        check("rw2_ready", int'(dispatch_ready), 0);
        next_cycle();
        @(negedge clock);
        check("rw3_valid", int'(rewind_valid), 2);
        check("rw3_arch1", int'(rewind_arch_dst[1]), 4);
        check("rw3_ready", int'(dispatch_ready), 0);
        next_cycle();
        drive_disp(2'b11, 2'b11);
        @(negedge clock);
        check("rw_done_rewinding", int'(rewinding), 0);
        check("rw_done_ready", int'(dispatch_ready), 1);
        check("rw_done_idx0", int'(dispatch_idx[0]), 4);
        next_cycle();

        // Mispredict on the youngest entry: nothing to remove
        mispredict_valid = 1'b1; mispredict_idx = 5'd5;
        next_cycle();
        @(negedge clock);
        check("young_rewinding", int'(rewinding), 0);
        check("young_ready", int'(dispatch_ready), 1);
        check("young_rewind_valid", int'(rewind_valid), 0);
        next_cycle();

        // Wrap-around: drain to head=tail=30, dispatch across the wrap, rewind to 31
        do_reset();
        for (int c = 0; c < 15; c++) begin drive_disp(2'b11, 2'b11); next_cycle(); end
        for (int c = 0; c < 15; c++) begin
            complete_valid = 2'b11;
            complete_idx[0] = rob_idx_t'(2 * c);
            complete_idx[1] = rob_idx_t'(2 * c + 1);
            next_cycle();
        end
        repeat (2) next_cycle();
        drive_disp(2'b11, 2'b11);
        @(negedge clock);
        check("wrap_idx30", int'(dispatch_idx[0]), 30);
        check("wrap_idx31", int'(dispatch_idx[1]), 31);
        next_cycle();
        drive_disp(2'b11, 2'b01);
        @(negedge clock);
        check("wrap_idx0", int'(dispatch_idx[0]), 0);
        check("wrap_idx1", int'(dispatch_idx[1]), 1);
        next_cycle();
        mispredict_valid = 1'b1; mispredict_idx = 5'd31;
        next_cycle();
        @(negedge clock);
        check("wrap_rw_valid", int'(rewind_valid), 2);
        check("wrap_rw_arch1", int'(rewind_arch_dst[1]), 32 % 32);
        next_cycle();
        drive_disp(2'b11, 2'b11);
        @(negedge clock);
        check("wrap_done_rewinding", int'(rewinding), 0);
        check("wrap_tail0", int'(dispatch_idx[0]), 0);
        next_cycle();

        // Reset in the middle of a rewind
        do_reset();
        for (int c = 0; c < 5; c++) begin drive_disp(2'b11, 2'b11); next_cycle(); end
        mispredict_valid = 1'b1; mispredict_idx = 5'd2;
        next_cycle();
        @(negedge clock);
        check("rstmid_rewinding_before", int'(rewinding), 1);
        @(posedge clock);
        #1;
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rstmid_rewinding", int'(rewinding), 0);
        check("rstmid_rewind_valid", int'(rewind_valid), 0);
        check("rstmid_ready", int'(dispatch_ready), 1);
        check("rstmid_retire_valid", int'(retire_valid), 0);
        repeat (3) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
